instr_fetch_unit: RTL and testbench

//   Upstream neighbour of controlPath: owns the PC, fetches instruction words from

---
 rtl/instr_fetch_if.sv | 27 ++
 rtl/instr_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction memory handshake, decode output and control feedback.
// imem_req/imem_ready: a word moves in every cycle where both are high; req holds addr stable until then.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruct;
  logic        instr_valid;
  logic        stall;
  logic        branch;
  logic        zero;
  logic        pcOp;
  logic [31:0] ret_addr;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  modport master (
    output imem_req, imem_addr, instruct, instr_valid, pc_plus4, fetch_err,
    input  imem_ready, imem_rdata, stall, branch, zero, pcOp, ret_addr
  );

  modport slave (
    input  imem_req, imem_addr, instruct, instr_valid, pc_plus4, fetch_err,
    output imem_ready, imem_rdata, stall, branch, zero, pcOp, ret_addr
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC owner and instruction fetch FSM (FETCH -> DECODE -> EXEC), with branch/ret redirects.
// Optional macro FETCH_TIMEOUT_EN adds a fetch wait timeout, sticky fetch_err and HALT state.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          DECODE_LAT  = 1,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus,
  output logic [1:0]    o_state
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  localparam logic [7:0] LAT_C = 8'(DECODE_LAT);

  state_t      r_state;
  state_t      w_next;
  logic        r_hold;
  logic [31:0] r_pc;
  logic [31:0] r_instruct;
  logic        r_instr_valid;
  logic [7:0]  r_dec_cnt;
  logic        w_req;
  logic        w_accept;
  logic        w_leave_exec;
  logic        w_timeout;
  logic [31:0] w_offset;
  logic [31:0] w_next_pc;
  logic        w_unused_bits;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] r_wait_cnt;
  logic       r_fetch_err;
`endif

  // r_hold keeps imem_req low in the cycle right after rst is sampled high.
  always_ff @(posedge clk) begin
    r_hold <= rst;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_req        = 1'b0;
    w_accept     = 1'b0;
    w_leave_exec = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_req = !r_hold;
        if (w_req && bus.imem_ready) begin
          w_accept = 1'b1;
          w_next   = S_DECODE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (w_req && (r_wait_cnt == TMO_LAST)) begin
          w_timeout = 1'b1;
          w_next    = S_HALT;
        end
`endif
      end
      S_DECODE: begin
        if (r_dec_cnt == LAT_C) w_next = S_EXEC;
      end
      S_EXEC: begin
        if (!bus.stall) begin
          w_leave_exec = 1'b1;
          w_next       = S_FETCH;
        end
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  assign w_offset = {{14{r_instruct[15]}}, r_instruct[15:0], 2'b00};

  always_comb begin
    w_next_pc = r_pc + 32'd4;
    if (bus.pcOp)                    w_next_pc = {bus.ret_addr[31:2], 2'b00};
    else if (bus.branch && bus.zero) w_next_pc = r_pc + 32'd4 + w_offset;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_instruct    <= 32'd0;
      r_instr_valid <= 1'b0;
      r_dec_cnt     <= 8'd0;
    end else begin
      if (w_accept) begin
        r_instruct    <= bus.imem_rdata;
        r_instr_valid <= 1'b1;
        r_dec_cnt     <= 8'd0;
      end
      if ((r_state == S_DECODE) && (r_dec_cnt != LAT_C)) r_dec_cnt <= r_dec_cnt + 8'd1;
      if (w_leave_exec) begin
        r_pc          <= w_next_pc;
        r_instr_valid <= 1'b0;
      end
      if (w_timeout) r_instr_valid <= 1'b0;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt  <= 8'd0;
      r_fetch_err <= 1'b0;
    end else begin
      if (w_accept || w_leave_exec)        r_wait_cnt <= 8'd0;
      else if (w_req && !bus.imem_ready)   r_wait_cnt <= r_wait_cnt + 8'd1;
      if (w_timeout) r_fetch_err <= 1'b1;
    end
  end
  assign bus.fetch_err = r_fetch_err;
`else
  assign bus.fetch_err = 1'b0;
`endif

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_pc;
  assign bus.instruct    = r_instruct;
  assign bus.instr_valid = r_instr_valid;
  assign bus.pc_plus4    = r_pc + 32'd4;
  assign o_state         = r_state;
  assign w_unused_bits   = &{1'b0, bus.ret_addr[1:0]};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed redirect cases plus randomized fetches vs a PC model.
module tb_instr_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          LAT      = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         checks   = 0;
  int         failures = 0;
  logic [31:0] exp_q[$];

  instr_fetch_if bus();

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DECODE_LAT(LAT), .TIMEOUT_CYC(255)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] word,
                                             input logic br, input logic z, input logic op,
                                             input logic [31:0] ra);
    logic signed [31:0] off;
    off = $signed(word[15:0]);
    if (op)      return ra & 32'hFFFF_FFFC;
    if (br && z) return pc + 32'd4 + off * 4;
    return pc + 32'd4;
  endfunction

  // ---------------- driver: one full instruction ----------------
  task automatic fetch_instr(input logic [31:0] word, input int wait_cyc, input logic br,
                             input logic z, input logic op, input logic [31:0] ra,
                             input int stall_cyc);
    logic [31:0] exp_addr;
    exp_addr = exp_q.pop_front();
    bus.imem_ready = 1'b0;
    for (int i = 0; i < wait_cyc; i++) begin
      bus.imem_rdata = $urandom;
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_addr) begin
        failures++;
        $display("FAIL fetch_wait req=%b addr=%h expected req=1 addr=%h", bus.imem_req, bus.imem_addr, exp_addr);
      end
      step();
    end
    bus.imem_ready = 1'b1;
    bus.imem_rdata = word;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_addr) begin
      failures++;
      $display("FAIL fetch_addr req=%b addr=%h expected req=1 addr=%h", bus.imem_req, bus.imem_addr, exp_addr);
    end
    step();
    for (int i = 0; i < LAT + 1; i++) begin
      bus.imem_ready = 1'($urandom_range(0, 1));
      bus.imem_rdata = $urandom;
      bus.stall      = 1'($urandom_range(0, 1));
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instruct !== word || bus.imem_req !== 1'b0 ||
          bus.pc_plus4 !== exp_addr + 32'd4) begin
        failures++;
        $display("FAIL decode valid=%b instr=%h req=%b pc4=%h expected 1 %h 0 %h",
                 bus.instr_valid, bus.instruct, bus.imem_req, bus.pc_plus4, word, exp_addr + 32'd4);
      end
      step();
    end
    for (int i = 0; i < stall_cyc; i++) begin
      bus.stall    = 1'b1;
      bus.branch   = 1'($urandom_range(0, 1));
      bus.zero     = 1'($urandom_range(0, 1));
      bus.pcOp     = 1'($urandom_range(0, 1));
      bus.ret_addr = $urandom;
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instruct !== word || bus.imem_req !== 1'b0 ||
          bus.imem_addr !== exp_addr) begin
        failures++;
        $display("FAIL stall_hold valid=%b instr=%h req=%b pc=%h expected 1 %h 0 %h",
                 bus.instr_valid, bus.instruct, bus.imem_req, bus.imem_addr, word, exp_addr);
      end
      step();
    end
    bus.stall      = 1'b0;
    bus.branch     = br;
    bus.zero       = z;
    bus.pcOp       = op;
    bus.ret_addr   = ra;
    bus.imem_ready = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instruct !== word || bus.imem_req !== 1'b0) begin
      failures++;
      $display("FAIL exec valid=%b instr=%h req=%b expected 1 %h 0", bus.instr_valid, bus.instruct, bus.imem_req, word);
    end
    step();
    bus.branch   = 1'($urandom_range(0, 1));
    bus.zero     = 1'($urandom_range(0, 1));
    bus.pcOp     = 1'($urandom_range(0, 1));
    bus.ret_addr = $urandom;
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL retire valid=%b expected 0", bus.instr_valid);
    end
    exp_q.push_back(model_next(exp_addr, word, br, z, op, ra));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.imem_ready = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    bus.stall = 1'b0; bus.branch = 1'b0; bus.zero = 1'b0; bus.pcOp = 1'b0; bus.ret_addr = 32'd0;
    repeat (3) step();
    checks++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instruct !== 32'd0 ||
        bus.fetch_err !== 1'b0 || bus.pc_plus4 !== RESET_PC + 32'd4) begin
      failures++;
      $display("FAIL reset req=%b valid=%b instr=%h err=%b pc4=%h expected 0 0 0 0 %h",
               bus.imem_req, bus.instr_valid, bus.instruct, bus.fetch_err, bus.pc_plus4, RESET_PC + 32'd4);
    end
    bus.imem_ready = 1'b0;
    rst = 1'b0;
    step();
    exp_q.delete();
    exp_q.push_back(RESET_PC);
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) fetch_instr(32'd0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 0);
  endtask

  task automatic test_branch();
    fetch_instr(32'h1234_FFFE, 0, 1'b1, 1'b1, 1'b0, 32'd0, 0);
    fetch_instr(32'h0000_0000, 1, 1'b0, 1'b0, 1'b0, 32'd0, 0);
    fetch_instr(32'h0000_FFFE, 0, 1'b1, 1'b0, 1'b0, 32'd0, 0);
    fetch_instr(32'h0000_0010, 2, 1'b1, 1'b1, 1'b0, 32'd0, 0);
  endtask

  task automatic test_ret();
    fetch_instr($urandom, 0, 1'b1, 1'b1, 1'b1, 32'h0000_0123, 0);
  endtask

  task automatic test_stall();
    fetch_instr($urandom, 0, 1'b0, 1'b0, 1'b0, 32'd0, 5);
  endtask

  task automatic test_wrap();
    fetch_instr($urandom, 0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 0);
    fetch_instr(32'h0000_0001, 0, 1'b0, 1'b1, 1'b0, 32'd0, 0);
    fetch_instr(32'h0000_8000, 0, 1'b1, 1'b1, 1'b0, 32'd0, 0);
  endtask

  task automatic test_no_ready();
    int bad;
    bad = 0;
    bus.imem_ready = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 254; i++) begin
      if (bus.imem_req !== 1'b1 || bus.fetch_err !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0 || bus.imem_req !== 1'b1 || bus.fetch_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early bad_cycles=%0d req=%b err=%b expected 0 1 0", bad, bus.imem_req, bus.fetch_err);
    end
    step();
    checks++;
    if (bus.fetch_err !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout err=%b req=%b valid=%b expected 1 0 0", bus.fetch_err, bus.imem_req, bus.instr_valid);
    end
    bus.imem_ready = 1'b1;
    repeat (4) step();
    checks++;
    if (bus.fetch_err !== 1'b1 || bus.instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL halt_sticky err=%b valid=%b expected 1 0", bus.fetch_err, bus.instr_valid);
    end
    bus.imem_ready = 1'b0;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
    exp_q.delete();
    exp_q.push_back(RESET_PC);
`else
    for (int i = 0; i < 300; i++) begin
      if (bus.imem_req !== 1'b1 || bus.fetch_err !== 1'b0 || bus.imem_addr !== exp_q[0]) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL no_timeout bad_cycles=%0d expected 0", bad);
    end
`endif
    fetch_instr(32'h0000_0003, 0, 1'b1, 1'b1, 1'b0, 32'd0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++)
      fetch_instr($urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 2));
  endtask

  task automatic test_reset_midfetch();
    bus.imem_ready = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instruct !== 32'd0 ||
          bus.imem_addr !== RESET_PC) begin
        failures++;
        $display("FAIL reset_midfetch req=%b valid=%b instr=%h pc=%h expected 0 0 0 %h",
                 bus.imem_req, bus.instr_valid, bus.instruct, bus.imem_addr, RESET_PC);
      end
    end
    bus.imem_ready = 1'b0;
    rst = 1'b0;
    step();
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    fetch_instr(32'h0000_0007, 1, 1'b0, 1'b0, 1'b0, 32'd0, 0);
    fetch_instr(32'h0000_0000, 0, 1'b0, 1'b0, 1'b0, 32'd0, 0);
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_ret();
    test_stall();
    test_wrap();
    test_no_ready();
    test_random();
    test_reset_midfetch();
    // Drain: the last model prediction must match the address now being fetched.
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_q[0]) begin
      failures++;
      $display("FAIL final_addr req=%b addr=%h expected 1 %h", bus.imem_req, bus.imem_addr, exp_q[0]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
